// File: rtl/button_event_queue_pkg.sv
// Shared constants, event-code type and the round-robin search helper for
// the button event queue.
package button_pkg;

    localparam int NUM_BTN_DEFAULT = 4;
    localparam int DEPTH_DEFAULT   = 4;
    localparam int CW_DEFAULT      = $clog2(NUM_BTN_DEFAULT);

    // Widest button bank the arbiter search is written for.
    localparam int MAX_BTN = 16;

    typedef logic [CW_DEFAULT-1:0] btn_code_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } rr_pick_t;

    // First set bit of vec[n-1:0], searching upward from start and wrapping
    // at n. start must already be in 0..n-1.
    function automatic rr_pick_t rr_pick(input logic [MAX_BTN-1:0] vec,
                                         input int n,
                                         input int start);
        rr_pick_t res;
        int       pos;
        res = '0;
        for (int k = 0; k < MAX_BTN; k++) begin
            if (k < n) begin
                pos = start + k;
                if (pos >= n) begin
                    pos = pos - n;
                end
                if (!res.valid && vec[pos[3:0]]) begin
                    res.valid = 1'b1;
                    res.idx   = pos[3:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/button_event_queue_if.sv
// Button press inputs, pending/status outputs and the valid/ready event
// stream. master = the queue, slave = the press source / event consumer.
interface button_event_queue_if
    import button_pkg::*;
#(
    parameter int NUM_BTN = NUM_BTN_DEFAULT,
    parameter int CW      = $clog2(NUM_BTN)
);
    logic [NUM_BTN-1:0] press;
    logic               evt_valid;
    logic [CW-1:0]      evt_code;
    logic               evt_ready;
    logic [NUM_BTN-1:0] pending;
    logic               full;
    logic               overflow;

    modport master (
        input  press, evt_ready,
        output evt_valid, evt_code, pending, full, overflow
    );

    modport slave (
        output press, evt_ready,
        input  evt_valid, evt_code, pending, full, overflow
    );
endinterface

// File: rtl/button_event_queue_event_fifo.sv
// First-word-fall-through FIFO: head_o shows the oldest entry whenever
// count_o is non-zero. Push while full is accepted only alongside a pop.
module event_fifo
    import button_pkg::*;
#(
    parameter int  WIDTH = CW_DEFAULT,
    parameter int  DEPTH = DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [AW:0]      count_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // Qualify push/pop and compute next pointers and occupancy.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && (!full_o || do_pop);
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Write the pushed entry into storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; stale words are never visible because
        // head_o is only meaningful while count is non-zero.
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/button_event_queue.sv
// Latches press pulses into pending bits, grants one pending button per
// cycle round-robin into an event FIFO, and flags coalesced repeat presses.
module button_event_queue
    import button_pkg::*;
#(
    parameter int NUM_BTN = NUM_BTN_DEFAULT,
    parameter int DEPTH   = DEPTH_DEFAULT,
    parameter int CW      = $clog2(NUM_BTN)
) (
    input logic                  clk,
    input logic                  rst,
    button_event_queue_if.master bus
);

    localparam int AW = $clog2(DEPTH);

    logic [NUM_BTN-1:0] pending_q, pending_d;
    logic [NUM_BTN-1:0] grant_oh;
    logic [CW-1:0]      last_grant_q, last_grant_d;
    logic [CW-1:0]      grant_idx;
    logic               overflow_q, overflow_d;
    logic               grant_valid;
    logic               pop, push_ok, evt_valid;
    logic [CW-1:0]      head;
    logic [AW:0]        count;
    logic               fifo_full;
    rr_pick_t           pick;
    int                 start_idx;

    assign evt_valid = (count != '0);
    assign pop       = evt_valid && bus.evt_ready;
    assign push_ok   = (count < (AW+1)'(DEPTH)) || pop;

    // Arbitrate, update pending bits and detect coalesced presses.
    always_comb begin
        start_idx = (int'(last_grant_q) == NUM_BTN - 1) ? 0 : int'(last_grant_q) + 1;
        pick        = rr_pick(MAX_BTN'(pending_q), NUM_BTN, start_idx);
        grant_valid = pick.valid && push_ok;
        grant_idx   = CW'(pick.idx);
        grant_oh    = '0;
        if (grant_valid) begin
            grant_oh[grant_idx] = 1'b1;
        end
        // A press on the granted button re-arms its bit: set beats clear.
        pending_d    = (pending_q & ~grant_oh) | bus.press;
        overflow_d   = |(bus.press & pending_q & ~grant_oh);
        last_grant_d = grant_valid ? grant_idx : last_grant_q;
    end

    // Pending, arbiter history and overflow pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q    <= '0;
            last_grant_q <= CW'(NUM_BTN - 1);
            overflow_q   <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            last_grant_q <= last_grant_d;
            overflow_q   <= overflow_d;
        end
    end

    event_fifo #(
        .WIDTH(CW),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (grant_valid),
        .data_i (grant_idx),
        .pop_i  (pop),
        .head_o (head),
        .count_o(count),
        .full_o (fifo_full)
    );

    assign bus.evt_valid = evt_valid;
    assign bus.evt_code  = evt_valid ? head : '0;
    assign bus.pending   = pending_q;
    assign bus.full      = fifo_full;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_button_event_queue.sv
// Directed tests for button_event_queue with NUM_BTN=4, DEPTH=4.
module tb_button_event_queue;
    import button_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    button_event_queue_if #(.NUM_BTN(4), .CW(2)) bus ();

    button_event_queue #(
        .NUM_BTN(4),
        .DEPTH  (4),
        .CW     (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.press     = '0;
        bus.evt_ready = 1'b0;
        rst           = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.press     = '0;
        bus.evt_ready = 1'b0;
        step();
        n_checks++;
        if (bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.evt_valid); end
        n_checks++;
        if (bus.evt_code !== 2'd0) begin n_fail++; $display("FAIL reset_code: got %0d want 0", bus.evt_code); end
        n_checks++;
        if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.full); end
        n_checks++;
        if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
        n_checks++;
        if (bus.pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending: got %b want 0000", bus.pending); end
        rst = 1'b0;
    endtask

    task automatic test_single_press();
        do_reset();
        bus.press = 4'b0100;
        step();
        bus.press = '0;
        n_checks++;
        if (bus.pending !== 4'b0100) begin n_fail++; $display("FAIL single_pending: got %b want 0100", bus.pending); end
        n_checks++;
        if (bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", bus.evt_valid); end
        step();
        n_checks++;
        if (bus.evt_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", bus.evt_valid); end
        n_checks++;
        if (bus.evt_code !== 2'd2) begin n_fail++; $display("FAIL single_code: got %0d want 2", bus.evt_code); end
        n_checks++;
        if (bus.pending !== 4'b0000) begin n_fail++; $display("FAIL single_pending_clr: got %b want 0000", bus.pending); end
        bus.evt_ready = 1'b1;
        step();
        bus.evt_ready = 1'b0;
        n_checks++;
        if (bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid: got %b want 0", bus.evt_valid); end
        n_checks++;
        if (bus.evt_code !== 2'd0) begin n_fail++; $display("FAIL single_pop_code: got %0d want 0", bus.evt_code); end
    endtask

    task automatic test_simultaneous();
        btn_code_t exp_seq [3] = '{2'd0, 2'd1, 2'd3};
        do_reset();
        bus.evt_ready = 1'b1;
        bus.press     = 4'b1011;
        step();
        bus.press = '0;
        n_checks++;
        if (bus.pending !== 4'b1011) begin n_fail++; $display("FAIL simul_pending: got %b want 1011", bus.pending); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (bus.evt_valid !== 1'b1 || bus.evt_code !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL simul_event%0d: got valid=%b code=%0d want valid=1 code=%0d", i, bus.evt_valid, bus.evt_code, exp_seq[i]);
            end
            n_checks++;
            if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL simul_overflow%0d: got %b want 0", i, bus.overflow); end
        end
        step();
        bus.evt_ready = 1'b0;
        n_checks++;
        if (bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL simul_drained: got %b want 0", bus.evt_valid); end
    endtask

    task automatic test_round_robin();
        btn_code_t exp_seq [2] = '{2'd3, 2'd0};
        do_reset();
        bus.evt_ready = 1'b1;
        bus.press     = 4'b0010;
        step();
        bus.press = 4'b1001;
        step();
        bus.press = '0;
        n_checks++;
        if (bus.pending !== 4'b1001) begin n_fail++; $display("FAIL rr_pending: got %b want 1001", bus.pending); end
        n_checks++;
        if (bus.evt_code !== 2'd1) begin n_fail++; $display("FAIL rr_first: got %0d want 1", bus.evt_code); end
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (bus.evt_valid !== 1'b1 || bus.evt_code !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL rr_event%0d: got valid=%b code=%0d want valid=1 code=%0d", i, bus.evt_valid, bus.evt_code, exp_seq[i]);
            end
        end
        step();
        bus.evt_ready = 1'b0;
        n_checks++;
        if (bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drained: got %b want 0", bus.evt_valid); end
    endtask

    task automatic test_full_coalesce();
        btn_code_t exp_seq [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.press = 4'b0001 << i;
            step();
        end
        bus.press = '0;
        n_checks++;
        if (bus.full !== 1'b0) begin n_fail++; $display("FAIL full_at3: got %b want 0", bus.full); end
        step();
        n_checks++;
        if (bus.full !== 1'b1) begin n_fail++; $display("FAIL full_at4: got %b want 1", bus.full); end
        n_checks++;
        if (bus.pending !== 4'b0000) begin n_fail++; $display("FAIL full_pending: got %b want 0000", bus.pending); end
        bus.press = 4'b0001;
        step();
        n_checks++;
        if (bus.pending !== 4'b0001 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL coal_first: got pending=%b overflow=%b want 0001/0", bus.pending, bus.overflow);
        end
        step();
        bus.press = '0;
        n_checks++;
        if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL coal_pulse: got %b want 1", bus.overflow); end
        step();
        n_checks++;
        if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL coal_pulse_end: got %b want 0", bus.overflow); end
        n_checks++;
        if (bus.pending !== 4'b0001 || bus.full !== 1'b1 || bus.evt_code !== 2'd0) begin
            n_fail++;
            $display("FAIL coal_hold: got pending=%b full=%b code=%0d want 0001/1/0", bus.pending, bus.full, bus.evt_code);
        end
        bus.evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (bus.evt_valid !== 1'b1 || bus.evt_code !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL drain_event%0d: got valid=%b code=%0d want valid=1 code=%0d", i, bus.evt_valid, bus.evt_code, exp_seq[i]);
            end
        end
        step();
        bus.evt_ready = 1'b0;
        n_checks++;
        if (bus.evt_valid !== 1'b0 || bus.full !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty: got valid=%b full=%b want 0/0", bus.evt_valid, bus.full);
        end
    endtask

    task automatic test_collision();
        do_reset();
        bus.press = 4'b0010;
        step();
        step();
        bus.press = '0;
        n_checks++;
        if (bus.pending !== 4'b0010 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL coll_setwins: got pending=%b overflow=%b want 0010/0", bus.pending, bus.overflow);
        end
        n_checks++;
        if (bus.evt_code !== 2'd1) begin n_fail++; $display("FAIL coll_head: got %0d want 1", bus.evt_code); end
        step();
        n_checks++;
        if (bus.pending !== 4'b0000 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL coll_second: got pending=%b overflow=%b want 0000/0", bus.pending, bus.overflow);
        end
        bus.evt_ready = 1'b1;
        step();
        n_checks++;
        if (bus.evt_valid !== 1'b1 || bus.evt_code !== 2'd1) begin
            n_fail++;
            $display("FAIL coll_repeat: got valid=%b code=%0d want 1/1", bus.evt_valid, bus.evt_code);
        end
        step();
        bus.evt_ready = 1'b0;
        n_checks++;
        if (bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL coll_drained: got %b want 0", bus.evt_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.press = 4'b0001;
        step();
        bus.press = 4'b0010;
        step();
        bus.press = 4'b1000;
        step();
        bus.press = 4'b0000;
        step();
        bus.press = 4'b0110;
        step();
        bus.press = '0;
        n_checks++;
        if (bus.pending !== 4'b0110 || bus.evt_valid !== 1'b1 || bus.evt_code !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_setup: got pending=%b valid=%b code=%0d want 0110/1/0", bus.pending, bus.evt_valid, bus.evt_code);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.evt_valid !== 1'b0 || bus.evt_code !== 2'd0 || bus.full !== 1'b0 ||
            bus.overflow !== 1'b0 || bus.pending !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_async: got valid=%b code=%0d full=%b ovf=%b pending=%b want all 0",
                     bus.evt_valid, bus.evt_code, bus.full, bus.overflow, bus.pending);
        end
        step();
        rst           = 1'b0;
        bus.evt_ready = 1'b1;
        bus.press     = 4'b0001;
        step();
        bus.press = '0;
        n_checks++;
        if (bus.pending !== 4'b0001 || bus.evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_after_pending: got pending=%b valid=%b want 0001/0", bus.pending, bus.evt_valid);
        end
        step();
        n_checks++;
        if (bus.evt_valid !== 1'b1 || bus.evt_code !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_first_event: got valid=%b code=%0d want 1/0", bus.evt_valid, bus.evt_code);
        end
        step();
        bus.evt_ready = 1'b0;
        n_checks++;
        if (bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_stale: got %b want 0", bus.evt_valid); end
    endtask

    initial begin
        rst           = 1'b1;
        bus.press     = '0;
        bus.evt_ready = 1'b0;
        test_reset();
        test_single_press();
        test_simultaneous();
        test_round_robin();
        test_full_coalesce();
        test_collision();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_event_queue.md
# button_event_queue

Collects one-cycle press pulses from a bank of `ButtonDetector` instances and turns them into an ordered stream of button-index events. Each press is latched into a per-button pending bit, arbitrated round-robin, and pushed into a small first-word-fall-through FIFO. A downstream controller pops events with a valid/ready handshake. No press is lost while the FIFO has room. Repeat presses of an already-pending button are coalesced and flagged.

## Interface

Parameters:
- `NUM_BTN`, default 4: number of button inputs; valid range 2..16.
- `DEPTH`, default 4: FIFO entries; must be a power of 2, at least 2.
- `CW`, default `$clog2(NUM_BTN)`: width of an event code (derived).

Ports:
- `clk`  in  1: single system clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `press`  in  NUM_BTN: one-cycle rising-edge pulses, one per button, already synchronous to `clk`.
- `evt_valid`  out  1: FIFO head holds an event.
- `evt_code`  out  CW: button index at the FIFO head; forced to 0 when `evt_valid`=0.
- `evt_ready`  in  1: consumer accepts the head this cycle.
- `pending`  out  NUM_BTN: latched, not-yet-enqueued presses.
- `full`  out  1: FIFO holds DEPTH entries.
- `overflow`  out  1: one-cycle pulse when at least one press is coalesced this cycle.

## Operation

- **Pending register**
  - `press[i]` sets `pending[i]` at the next edge.
  - A grant to index i clears `pending[i]`.
  - If `press[i]` and a grant to i happen in the same cycle, set wins. The bit stays 1, and a second event for i is enqueued later.
- **Coalescing**
  - If `press[i]`=1 while `pending[i]`=1 and i is not granted that cycle, the press merges into the existing pending bit.
  - The merge pulses `overflow` for exactly one cycle. Multiple coalesced presses in one cycle still give a single pulse.
- **Arbiter**
  - Round-robin over the registered `pending` vector.
  - Search starts at index (last_grant+1) mod NUM_BTN.
  - `last_grant` resets to NUM_BTN-1, so index 0 has priority first after reset.
  - At most one grant per cycle.
  - A grant occurs only when `pending` is non-zero and `push_ok` = (count < DEPTH) or (pop this cycle).
- **FIFO**
  - Read/write pointers of `$clog2(DEPTH)` bits that wrap naturally, plus a count of `$clog2(DEPTH)+1` bits.
  - `pop` = `evt_valid` and `evt_ready`.
  - Push and pop in the same cycle leave count unchanged; this is legal when full and when count is 1.
  - `full` = (count == DEPTH). `evt_valid` = (count != 0).
  - Pop while empty is ignored; no pointer movement.
- **Reset (async, any time, including mid-transfer)**
  - `pending`=0, count=0, pointers=0, `last_grant`=NUM_BTN-1.
  - Outputs: `evt_valid`=0, `evt_code`=0, `full`=0, `overflow`=0.
  - FIFO storage contents are don't-care.

## Timing

- Press pulse sampled at edge k → `pending[i]`=1 after edge k.
- Grant at edge k+1 → `evt_valid`=1 and `evt_code`=i after edge k+1. Latency is 2 edges when the FIFO is not full.
- `evt_code` is stable while `evt_valid`=1 and `evt_ready`=0.
- The pop takes effect at the edge where `evt_ready`=1 is sampled. The next head, if any, is visible after that edge.
- When full with no pop, `pending` bits persist indefinitely; further presses on those buttons coalesce.
- `overflow` is registered and high for the cycle after the offending press.
- Sustained throughput: one event per cycle when `evt_ready` is held high.

## Structure

- Shared package `button_pkg`:
  - `NUM_BTN_DEFAULT` and `DEPTH_DEFAULT` constants.
  - The `btn_code_t` typedef (CW bits).
  - A `rr_pick` function: vector + start index → grant index and grant-valid.
- One sub-module, `event_fifo`: synchronous FWFT FIFO parameterised on width and depth, exposing push, pop, head, count and full.
- Pending register, arbiter and overflow logic live in the top.

## Test plan

- **Single press:** after reset, `press`=4'b0100 for one cycle.
  - `pending`=0100 one cycle later.
  - `evt_valid`=1, `evt_code`=2 two edges after the press.
  - Pop with `evt_ready`=1 → `evt_valid`=0.
- **Simultaneous presses:** `press`=4'b1011 in one cycle, `evt_ready`=1.
  - Events emerge in order 0, 1, 3 on consecutive cycles.
  - `overflow` stays 0.
- **Round-robin fairness:** with `last_grant`=1, `pending`=1001.
  - Grant goes to 3 before 0.
- **Full FIFO and coalescing** (DEPTH=4, `evt_ready`=0):
  - Press buttons 0, 1, 2, 3 on separate cycles → `full`=1 after the 4th grant.
  - Then press 0 twice → `pending[0]`=1, `overflow` pulses once on the second press.
  - Raise `evt_ready` → codes 0, 1, 2, 3, 0 come out in that order.
- **Grant/press collision:** `press[1]` asserted in the same cycle `pending[1]` is granted.
  - Code 1 is enqueued twice; `overflow`=0.
- **Reset mid-operation:** assert `rst` asynchronously with 3 entries queued and `pending`=0110.
  - All outputs go 0 immediately.
  - After release, the first press on button 0 is the first event out.
